sync_fifo_flags: RTL

- Parametrised synchronous FIFO with first-word-fall-through (FWFT) and valid/ready handshakes on both sides.
- Next generation of the team's basic sync FIFO. Adds:
  - all FIFO_DEPTH entries usable, including non-power-of-2 depths;
  - occupancy count output;
  - programmable almost-full and almost-empty flags;
  - synchronous flush;
  - sticky overflow and underflow error flags.
- Sits between streaming producer and consumer blocks in a single clock domain.

---
 rtl/sync_fifo_flags.sv | 59 +++++
 1 files changed

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: FWFT synchronous FIFO with occupancy count, threshold flags, flush and sticky errors
module sync_fifo_flags #(
  parameter int DATA_WIDTH          = 32,
  parameter int FIFO_DEPTH          = 64,
  parameter int ALMOST_FULL_THRESH  = 56,
  parameter int ALMOST_EMPTY_THRESH = 8,
  localparam int PTR_W = $clog2(FIFO_DEPTH),
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  flush_i,
  input  logic                  in_vld_i,
  output logic                  in_rdy_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  out_vld_o,
  input  logic                  out_rdy_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic [CNT_W-1:0]      count_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic                  push, pop, clr;
  assign clr            = srst | flush_i;
  assign empty_o        = count_o == '0;
  assign full_o         = count_o == CNT_W'(FIFO_DEPTH);
  assign almost_full_o  = count_o >= CNT_W'(ALMOST_FULL_THRESH);
  assign almost_empty_o = count_o <= CNT_W'(ALMOST_EMPTY_THRESH);
  assign in_rdy_o       = ~full_o;
  assign out_vld_o      = ~empty_o;
  assign push           = in_vld_i & in_rdy_o;
  assign pop            = out_vld_o & out_rdy_i;
  assign out_data_o     = mem[rd_ptr];
  // storage write; not cleared by reset, and a push coinciding with reset/flush is dropped
  always_ff @(posedge clk)
    if (push & ~clr) mem[wr_ptr] <= in_data_i;
  // pointers, occupancy and sticky error flags; reset and flush clear them alike
  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_o     <= '0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr == PTR_W'(FIFO_DEPTH - 1) ? '0 : wr_ptr + PTR_W'(1);
      if (pop) rd_ptr <= rd_ptr == PTR_W'(FIFO_DEPTH - 1) ? '0 : rd_ptr + PTR_W'(1);
      count_o <= count_o + CNT_W'(push) - CNT_W'(pop);
      if (in_vld_i & full_o) overflow_o <= 1'b1;
      if (out_rdy_i & empty_o) underflow_o <= 1'b1;
    end
  end
endmodule
